// File: rtl/pt_access_arbiter.sv
// Serialises two round-robin lookup requesters and one priority insert requester onto one page table port.
// Optional lookup timeout is enabled with `define PT_ARB_TIMEOUT_EN.
module pt_access_arbiter #(
   parameter int unsigned ADDR_W  = 5,
   parameter int unsigned ENTRY_W = 10,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               REQ_A_RQST,
   input  logic [ADDR_W-1:0]  REQ_A_ADDR,
   output logic               REQ_A_DONE,
   output logic [ENTRY_W-1:0] REQ_A_DATA,
   output logic               REQ_A_ERR,
   input  logic               REQ_B_RQST,
   input  logic [ADDR_W-1:0]  REQ_B_ADDR,
   output logic               REQ_B_DONE,
   output logic [ENTRY_W-1:0] REQ_B_DATA,
   output logic               REQ_B_ERR,
   input  logic               INS_RQST,
   input  logic [ADDR_W-1:0]  INS_INDX,
   input  logic [ENTRY_W-1:0] INS_ENTRY,
   output logic               INS_DONE,
   output logic               PT_LOOKUP_RQST,
   output logic [ADDR_W-1:0]  PT_LOOKUP_ADDR,
   input  logic               PT_LOOKUP_COMPLETE,
   input  logic [ENTRY_W-1:0] PT_LOOKUP_RETURN,
   output logic               PT_INSERT_RQST,
   output logic [ADDR_W-1:0]  PT_INSERT_INDX,
   output logic [ENTRY_W-1:0] PT_INSERT_ENTRY
);

   typedef enum logic [1:0] {IDLE, LOOKUP, INSERT, RELEASE} state_t;

   state_t               state_q, state_n;
   logic                 gnt_b_q, gnt_b_n;
   logic                 ptr_b_q, ptr_b_n;
   logic                 lk_rqst_q, lk_rqst_n;
   logic [ADDR_W-1:0]    lk_addr_q, lk_addr_n;
   logic                 ins_rqst_q, ins_rqst_n;
   logic [ADDR_W-1:0]    ins_indx_q, ins_indx_n;
   logic [ENTRY_W-1:0]   ins_entry_q, ins_entry_n;
   logic                 done_a_q, done_a_n, done_b_q, done_b_n;
   logic                 ins_done_q, ins_done_n;
   logic [ENTRY_W-1:0]   data_a_q, data_a_n, data_b_q, data_b_n;
   logic                 pick_b_c;
   logic                 fin_c;
   logic [ENTRY_W-1:0]   fin_data_c;

`ifdef PT_ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   logic [CNT_W-1:0]     cnt_q, cnt_n;
   logic                 err_a_q, err_a_n, err_b_q, err_b_n;
   logic                 fin_err_c;
`endif

   // Next-state and next-output logic
   always_comb begin
      state_n     = state_q;
      gnt_b_n     = gnt_b_q;
      ptr_b_n     = ptr_b_q;
      lk_rqst_n   = lk_rqst_q;
      lk_addr_n   = lk_addr_q;
      ins_rqst_n  = 1'b0;
      ins_indx_n  = ins_indx_q;
      ins_entry_n = ins_entry_q;
      done_a_n    = 1'b0;
      done_b_n    = 1'b0;
      ins_done_n  = 1'b0;
      data_a_n    = data_a_q;
      data_b_n    = data_b_q;
      fin_c       = 1'b0;
      fin_data_c  = '0;
      // B wins only when A is idle or the pointer favours B
      pick_b_c    = REQ_B_RQST && (!REQ_A_RQST || ptr_b_q);
`ifdef PT_ARB_TIMEOUT_EN
      cnt_n       = cnt_q;
      err_a_n     = 1'b0;
      err_b_n     = 1'b0;
      fin_err_c   = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (INS_RQST) begin
               ins_indx_n  = INS_INDX;
               ins_entry_n = INS_ENTRY;
               ins_rqst_n  = 1'b1;
               state_n     = INSERT;
            end else if (REQ_A_RQST || REQ_B_RQST) begin
               gnt_b_n   = pick_b_c;
               lk_addr_n = pick_b_c ? REQ_B_ADDR : REQ_A_ADDR;
               lk_rqst_n = 1'b1;
               state_n   = LOOKUP;
`ifdef PT_ARB_TIMEOUT_EN
               cnt_n     = '0;
`endif
            end
         end
         LOOKUP: begin
            if (PT_LOOKUP_COMPLETE) begin
               fin_c      = 1'b1;
               fin_data_c = PT_LOOKUP_RETURN;
`ifdef PT_ARB_TIMEOUT_EN
            end else if (cnt_q == CNT_W'(TIMEOUT)) begin
               fin_c     = 1'b1;
               fin_err_c = 1'b1;
            end else begin
               cnt_n = cnt_q + CNT_W'(1);
`endif
            end
         end
         INSERT: begin
            ins_done_n = 1'b1;
            state_n    = RELEASE;
         end
         RELEASE: state_n = IDLE;
         default: state_n = IDLE;
      endcase

      // Lookup completion (normal or timed out) for the granted side
      if (fin_c) begin
         lk_rqst_n = 1'b0;
         ptr_b_n   = !gnt_b_q;
         state_n   = RELEASE;
         if (gnt_b_q) begin
            done_b_n = 1'b1;
            data_b_n = fin_data_c;
`ifdef PT_ARB_TIMEOUT_EN
            err_b_n  = fin_err_c;
`endif
         end else begin
            done_a_n = 1'b1;
            data_a_n = fin_data_c;
`ifdef PT_ARB_TIMEOUT_EN
            err_a_n  = fin_err_c;
`endif
         end
      end
   end

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         gnt_b_q     <= 1'b0;
         ptr_b_q     <= 1'b0;
         lk_rqst_q   <= 1'b0;
         lk_addr_q   <= '0;
         ins_rqst_q  <= 1'b0;
         ins_indx_q  <= '0;
         ins_entry_q <= '0;
         done_a_q    <= 1'b0;
         done_b_q    <= 1'b0;
         ins_done_q  <= 1'b0;
         data_a_q    <= '0;
         data_b_q    <= '0;
`ifdef PT_ARB_TIMEOUT_EN
         cnt_q       <= '0;
         err_a_q     <= 1'b0;
         err_b_q     <= 1'b0;
`endif
      end else begin
         state_q     <= state_n;
         gnt_b_q     <= gnt_b_n;
         ptr_b_q     <= ptr_b_n;
         lk_rqst_q   <= lk_rqst_n;
         lk_addr_q   <= lk_addr_n;
         ins_rqst_q  <= ins_rqst_n;
         ins_indx_q  <= ins_indx_n;
         ins_entry_q <= ins_entry_n;
         done_a_q    <= done_a_n;
         done_b_q    <= done_b_n;
         ins_done_q  <= ins_done_n;
         data_a_q    <= data_a_n;
         data_b_q    <= data_b_n;
`ifdef PT_ARB_TIMEOUT_EN
         cnt_q       <= cnt_n;
         err_a_q     <= err_a_n;
         err_b_q     <= err_b_n;
`endif
      end
   end

   assign REQ_A_DONE      = done_a_q;
   assign REQ_A_DATA      = data_a_q;
   assign REQ_B_DONE      = done_b_q;
   assign REQ_B_DATA      = data_b_q;
   assign INS_DONE        = ins_done_q;
   assign PT_LOOKUP_RQST  = lk_rqst_q;
   assign PT_LOOKUP_ADDR  = lk_addr_q;
   assign PT_INSERT_RQST  = ins_rqst_q;
   assign PT_INSERT_INDX  = ins_indx_q;
   assign PT_INSERT_ENTRY = ins_entry_q;
`ifdef PT_ARB_TIMEOUT_EN
   assign REQ_A_ERR       = err_a_q;
   assign REQ_B_ERR       = err_b_q;
`else
   assign REQ_A_ERR       = 1'b0;
   assign REQ_B_ERR       = 1'b0;
`endif

endmodule

// File: tb/tb_pt_access_arbiter.sv
// Scoreboard bench for pt_access_arbiter: random request rounds predicted by a transaction-level service-order model.
module tb_pt_access_arbiter;
   localparam int unsigned ADDR_W  = 5;
   localparam int unsigned ENTRY_W = 10;

   logic               clk = 1'b0;
   logic               rst;
   logic               REQ_A_RQST, REQ_B_RQST, INS_RQST;
   logic [ADDR_W-1:0]  REQ_A_ADDR, REQ_B_ADDR, INS_INDX;
   logic [ENTRY_W-1:0] INS_ENTRY;
   logic               REQ_A_DONE, REQ_B_DONE, REQ_A_ERR, REQ_B_ERR, INS_DONE;
   logic [ENTRY_W-1:0] REQ_A_DATA, REQ_B_DATA;
   logic               PT_LOOKUP_RQST, PT_LOOKUP_COMPLETE, PT_INSERT_RQST;
   logic [ADDR_W-1:0]  PT_LOOKUP_ADDR, PT_INSERT_INDX;
   logic [ENTRY_W-1:0] PT_LOOKUP_RETURN, PT_INSERT_ENTRY;

   pt_access_arbiter #(.ADDR_W(ADDR_W), .ENTRY_W(ENTRY_W), .TIMEOUT(15)) dut (
      .clk(clk), .rst(rst),
      .REQ_A_RQST(REQ_A_RQST), .REQ_A_ADDR(REQ_A_ADDR), .REQ_A_DONE(REQ_A_DONE),
      .REQ_A_DATA(REQ_A_DATA), .REQ_A_ERR(REQ_A_ERR),
      .REQ_B_RQST(REQ_B_RQST), .REQ_B_ADDR(REQ_B_ADDR), .REQ_B_DONE(REQ_B_DONE),
      .REQ_B_DATA(REQ_B_DATA), .REQ_B_ERR(REQ_B_ERR),
      .INS_RQST(INS_RQST), .INS_INDX(INS_INDX), .INS_ENTRY(INS_ENTRY), .INS_DONE(INS_DONE),
      .PT_LOOKUP_RQST(PT_LOOKUP_RQST), .PT_LOOKUP_ADDR(PT_LOOKUP_ADDR),
      .PT_LOOKUP_COMPLETE(PT_LOOKUP_COMPLETE), .PT_LOOKUP_RETURN(PT_LOOKUP_RETURN),
      .PT_INSERT_RQST(PT_INSERT_RQST), .PT_INSERT_INDX(PT_INSERT_INDX),
      .PT_INSERT_ENTRY(PT_INSERT_ENTRY)
   );

   always #5 clk = ~clk;

   // kind: 0 = insert, 1 = lookup by A, 2 = lookup by B
   typedef struct {
      int                 kind;
      logic [ADDR_W-1:0]  addr;
      logic [ENTRY_W-1:0] data;
   } item_t;

   item_t              exp_q[$];
   logic [ENTRY_W-1:0] tb_mem  [32];
   logic [ENTRY_W-1:0] ref_mem [32];
   bit                 ref_ptr_b    = 1'b0;
   bit                 expect_abort = 1'b0;
   int                 fixed_delay  = -1;
   int                 total = 0;
   int                 bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Page table model: writes on insert, answers lookups after a delay
   initial begin
      bit busy;
      int dcnt;
      busy = 1'b0;
      dcnt = 0;
      PT_LOOKUP_COMPLETE = 1'b0;
      PT_LOOKUP_RETURN   = '0;
      forever begin
         tick();
         if (PT_INSERT_RQST) tb_mem[PT_INSERT_INDX] = PT_INSERT_ENTRY;
         PT_LOOKUP_COMPLETE = 1'b0;
         if (!PT_LOOKUP_RQST) busy = 1'b0;
         else if (!busy) begin
            busy = 1'b1;
            dcnt = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 4));
         end
         if (busy) begin
            if (dcnt == 0) begin
               PT_LOOKUP_COMPLETE = 1'b1;
               PT_LOOKUP_RETURN   = tb_mem[PT_LOOKUP_ADDR];
               busy = 1'b0;
            end else dcnt--;
         end
      end
   end

   // Monitor: pops the scoreboard on every DONE, peeks it on every table access
   initial begin
      bit pc, pi, pl;
      logic [ADDR_W-1:0] pa;
      item_t it;
      int nd, k;
      pc = 0; pi = 0; pl = 0; pa = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            pc = 0; pi = 0; pl = 0;
            continue;
         end
         nd = int'(REQ_A_DONE) + int'(REQ_B_DONE) + int'(INS_DONE);
         if (nd > 1) chk("single_done", nd, 1);
         if (REQ_A_DONE || REQ_B_DONE) chk("done_after_complete", pc, 1);
         if (INS_DONE) chk("ins_done_after_insert", pi, 1);
         if (nd > 0) begin
            if (exp_q.size() == 0) chk("done_with_nothing_pending", nd, 0);
            else begin
               it = exp_q.pop_front();
               k  = INS_DONE ? 0 : (REQ_A_DONE ? 1 : 2);
               chk("done_owner", k, it.kind);
               if (k == 1) chk("a_data", REQ_A_DATA, it.data);
               if (k == 2) chk("b_data", REQ_B_DATA, it.data);
               chk("err_flags", {REQ_A_ERR, REQ_B_ERR}, 0);
            end
         end
         if (PT_LOOKUP_RQST && !pl && !expect_abort) begin
            if (exp_q.size() == 0) chk("lookup_with_nothing_pending", 1, 0);
            else begin
               chk("lookup_kind", (exp_q[0].kind != 0), 1);
               chk("lookup_addr", PT_LOOKUP_ADDR, exp_q[0].addr);
            end
         end
         if (PT_LOOKUP_RQST && pl) chk("lookup_addr_stable", PT_LOOKUP_ADDR, pa);
         if (PT_INSERT_RQST) begin
            chk("insert_one_cycle", pi, 0);
            if (exp_q.size() == 0) chk("insert_with_nothing_pending", 1, 0);
            else begin
               chk("insert_kind", exp_q[0].kind, 0);
               chk("insert_indx", PT_INSERT_INDX, exp_q[0].addr);
               chk("insert_entry", PT_INSERT_ENTRY, exp_q[0].data);
            end
         end
         pc = PT_LOOKUP_COMPLETE;
         pi = PT_INSERT_RQST;
         pl = PT_LOOKUP_RQST;
         pa = PT_LOOKUP_ADDR;
      end
   end

   task automatic drive_lk(input bit side, input int n, input logic [ADDR_W-1:0] addr, input bit early);
      int seen = 0;
      int cyc  = 0;
      if (side) begin REQ_B_ADDR = addr; REQ_B_RQST = 1'b1; end
      else      begin REQ_A_ADDR = addr; REQ_A_RQST = 1'b1; end
      while (seen < n && cyc < 400) begin
         tick();
         cyc++;
         if (early && cyc == 1) begin
            if (side) REQ_B_RQST = 1'b0; else REQ_A_RQST = 1'b0;
         end
         if (side ? REQ_B_DONE : REQ_A_DONE) seen++;
      end
      if (side) REQ_B_RQST = 1'b0; else REQ_A_RQST = 1'b0;
      if (seen < n) chk(side ? "b_done_wait" : "a_done_wait", seen, n);
   endtask

   task automatic drive_ins(input logic [ADDR_W-1:0] ii, input logic [ENTRY_W-1:0] ie);
      int cyc = 0;
      bit seen = 1'b0;
      INS_INDX = ii; INS_ENTRY = ie; INS_RQST = 1'b1;
      while (!seen && cyc < 400) begin
         tick();
         cyc++;
         if (INS_DONE) seen = 1'b1;
      end
      INS_RQST = 1'b0;
      if (!seen) chk("ins_done_wait", seen, 1);
   endtask

   // One round: all requests raised together on an idle arbiter; model predicts the service order
   task automatic run_round(input bit do_ins, input logic [ADDR_W-1:0] ii, input logic [ENTRY_W-1:0] ie,
                            input int na, input logic [ADDR_W-1:0] aa,
                            input int nb, input logic [ADDR_W-1:0] ba, input bit drop);
      int ra = na;
      int rb = nb;
      bit first  = 1'b1;
      bit drop_a = 1'b0;
      bit drop_b = 1'b0;
      bit pb;
      logic [ADDR_W-1:0] ad;
      if (do_ins) begin
         exp_q.push_back('{0, ii, ie});
         ref_mem[ii] = ie;
      end
      while (ra > 0 || rb > 0) begin
         pb = (rb > 0) && (ra == 0 || ref_ptr_b);
         ad = pb ? ba : aa;
         exp_q.push_back('{pb ? 2 : 1, ad, ref_mem[ad]});
         if (first && drop && !do_ins) begin
            if (pb && nb == 1) drop_b = 1'b1;
            if (!pb && na == 1) drop_a = 1'b1;
         end
         first = 1'b0;
         ref_ptr_b = !pb;
         if (pb) rb--; else ra--;
      end
      fork
         if (do_ins) drive_ins(ii, ie);
         if (na > 0) drive_lk(1'b0, na, aa, drop_a);
         if (nb > 0) drive_lk(1'b1, nb, ba, drop_b);
      join
      repeat ($urandom_range(1, 3)) tick();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: actual=running required=finished");
      $fatal(1);
   end

   initial begin
      bit ok;
      rst = 1'b1;
      REQ_A_RQST = 0; REQ_B_RQST = 0; INS_RQST = 0;
      REQ_A_ADDR = '0; REQ_B_ADDR = '0; INS_INDX = '0; INS_ENTRY = '0;
      for (int i = 0; i < 32; i++) begin
         ref_mem[i] = ENTRY_W'($urandom);
         tb_mem[i]  = ref_mem[i];
      end
      repeat (2) tick();
      chk("rst_lookup_rqst", PT_LOOKUP_RQST, 0);
      chk("rst_insert_rqst", PT_INSERT_RQST, 0);
      chk("rst_dones", {REQ_A_DONE, REQ_B_DONE, INS_DONE}, 0);
      chk("rst_data", {REQ_A_DATA, REQ_B_DATA}, 0);
      rst = 1'b0;
      tick();

      // Single lookup, table answers after 2 cycles
      tb_mem[3] = 10'h2A5; ref_mem[3] = 10'h2A5;
      fixed_delay = 2;
      run_round(0, '0, '0, 1, 5'h03, 0, '0, 0);
      fixed_delay = -1;
      // Contention: both held for two lookups each
      run_round(0, '0, '0, 2, 5'h01, 2, 5'h02, 0);
      // Insert priority over simultaneous lookups, then read it back
      run_round(1, 5'h07, 10'h155, 1, 5'h01, 1, 5'h02, 0);
      run_round(0, '0, '0, 1, 5'h07, 0, '0, 0);
      chk("insert_readback_ref", ref_mem[7], 10'h155);
      // B drops its request right after the grant
      run_round(0, '0, '0, 0, '0, 1, 5'h09, 1);

      // Reset in the middle of a lookup while the pointer favours B
      run_round(0, '0, '0, 1, 5'h04, 0, '0, 0);
      expect_abort = 1'b1;
      fixed_delay  = 50;
      REQ_A_ADDR = 5'h06; REQ_A_RQST = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         tick();
         ok = PT_LOOKUP_RQST;
      end
      chk("abort_lookup_started", ok, 1);
      tick(); tick();
      #2 rst = 1'b1;
      #1;
      chk("async_rst_lookup", {PT_LOOKUP_RQST, PT_LOOKUP_ADDR}, 0);
      chk("async_rst_data_a", REQ_A_DATA, 0);
      chk("async_rst_outs", {REQ_A_DONE, REQ_B_DONE, INS_DONE, PT_INSERT_RQST, PT_INSERT_INDX, PT_INSERT_ENTRY}, 0);
      REQ_A_RQST = 1'b0;
      tick();
      rst = 1'b0;
      ref_ptr_b = 1'b0;
      repeat (4) tick();
      expect_abort = 1'b0;
      fixed_delay  = -1;
      run_round(0, '0, '0, 1, 5'h0A, 1, 5'h0B, 0);

      // Randomised rounds
      for (int r = 0; r < 40; r++) begin
         bit di;
         int na, nb;
         di = ($urandom_range(0, 3) == 0);
         na = int'($urandom_range(0, 2));
         nb = int'($urandom_range(0, 2));
         if (!di && na == 0 && nb == 0) na = 1;
         run_round(di, ADDR_W'($urandom), ENTRY_W'($urandom),
                   na, ADDR_W'($urandom), nb, ADDR_W'($urandom), ($urandom_range(0, 3) == 0));
      end

      repeat (5) tick();
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
